// File: rtl/pipe_stage_chain.sv
// Elastic valid/ready register chain placed between two CPU pipeline stages.
// Each stage holds a main register and, when SKID=1, a skid register so that
// its upstream ready comes straight from a flop. With SKID=0 ready ripples
// combinationally from the output back to the input. A flush empties every
// stage in one edge without touching the payload registers.
module pipe_stage_chain #(
  parameter int DATA_W = 32,
  parameter int STAGES = 1,
  parameter int SKID   = 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   flush_i,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic [DATA_W-1:0]                      in_data_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [DATA_W-1:0]                      out_data_o,
  output logic [$clog2(STAGES*(1+SKID)+1)-1:0]   occupancy_o
);

  localparam int CAP   = STAGES * (1 + SKID);
  localparam int OCC_W = $clog2(CAP + 1);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  logic [STAGES-1:0] mv;
  logic [STAGES-1:0] sv;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] dn_ready;
  logic [STAGES-1:0] in_fire;
  logic [STAGES-1:0] out_fire;
  logic [DATA_W-1:0] m_data [STAGES];
  logic              ready_en_q;
  logic [OCC_W-1:0]  occ_q;

  // Keep upstream ready low until the first edge after reset is released
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ready_en_q <= 1'b0;
    else        ready_en_q <= 1'b1;
  end

  // Ready walks from the output towards the input; fires are gated by flush
  always_comb begin
    logic dn;
    rdy        = '0;
    dn_ready   = '0;
    in_fire    = '0;
    out_fire   = '0;
    in_ready_o = 1'b0;
    dn         = out_ready_i;
    for (int k = STAGES - 1; k >= 0; k--) begin
      dn_ready[k] = dn;
      rdy[k]      = (SKID != 0) ? !sv[k] : (!mv[k] || dn);
      dn          = rdy[k];
    end
    in_ready_o = ready_en_q && rdy[0] && !flush_i;
    for (int k = 0; k < STAGES; k++) begin
      out_fire[k] = mv[k] && dn_ready[k] && !flush_i;
    end
    in_fire[0] = in_valid_i && in_ready_o;
    for (int k = 1; k < STAGES; k++) begin
      in_fire[k] = out_fire[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_state_e      state_q;
    stage_state_e      state_d;
    logic              load_m;
    logic              load_s;
    logic              shift_s;
    logic [DATA_W-1:0] up_data;
    logic [DATA_W-1:0] m_q;
    logic [DATA_W-1:0] s_q;

    if (k == 0) begin : g_head
      assign up_data = in_data_i;
    end else begin : g_body
      assign up_data = m_data[k-1];
    end

    assign mv[k]     = (state_q != EMPTY);
    assign sv[k]     = (state_q == FULL);
    assign m_data[k] = m_q;

    // Stage next state and which register captures on this edge
    always_comb begin
      state_d = state_q;
      load_m  = 1'b0;
      load_s  = 1'b0;
      shift_s = 1'b0;
      if (flush_i) begin
        state_d = EMPTY;
      end else begin
        case (state_q)
          EMPTY: begin
            if (in_fire[k]) begin
              state_d = BUSY;
              load_m  = 1'b1;
            end
          end
          BUSY: begin
            if (in_fire[k] && out_fire[k]) begin
              load_m = 1'b1;
            end else if (in_fire[k]) begin
              state_d = FULL;
              load_s  = 1'b1;
            end else if (out_fire[k]) begin
              state_d = EMPTY;
            end
          end
          FULL: begin
            if (out_fire[k]) begin
              state_d = BUSY;
              shift_s = 1'b1;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
    end

    // Stage state register
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= EMPTY;
      else        state_q <= state_d;
    end

    // Payload registers load only when a beat lands in them
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        m_q <= '0;
        s_q <= '0;
      end else begin
        if (load_m)       m_q <= up_data;
        else if (shift_s) m_q <= s_q;
        if (load_s)       s_q <= up_data;
      end
    end
  end

  // Beat count held in the chain: +1 per accept, -1 per delivery, 0 on flush
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      occ_q <= '0;
    end else if (flush_i) begin
      occ_q <= '0;
    end else begin
      case ({in_fire[0], out_fire[STAGES-1]})
        2'b10:   occ_q <= occ_q + OCC_ONE;
        2'b01:   occ_q <= occ_q - OCC_ONE;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign out_valid_o = mv[STAGES-1];
  assign out_data_o  = m_data[STAGES-1];
  assign occupancy_o = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: a 3-stage skid chain (u_a) and a
// 2-stage combinational-ready chain (u_b) share clock and reset.
module tb_pipe_stage_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [7:0] in_data_a, out_data_a;
  logic [2:0] occ_a;

  logic       flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [7:0] in_data_b, out_data_b;
  logic [1:0] occ_b;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_chain #(.DATA_W(8), .STAGES(3), .SKID(1)) u_a (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .flush_i     (flush_a),
    .in_valid_i  (in_valid_a),
    .in_ready_o  (in_ready_a),
    .in_data_i   (in_data_a),
    .out_valid_o (out_valid_a),
    .out_ready_i (out_ready_a),
    .out_data_o  (out_data_a),
    .occupancy_o (occ_a)
  );

  pipe_stage_chain #(.DATA_W(8), .STAGES(2), .SKID(0)) u_b (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .flush_i     (flush_b),
    .in_valid_i  (in_valid_b),
    .in_ready_o  (in_ready_b),
    .in_data_i   (in_data_b),
    .out_valid_o (out_valid_b),
    .out_ready_i (out_ready_b),
    .out_data_o  (out_data_b),
    .occupancy_o (occ_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int cyc;
    int first_acc;
    int n_out;
    int max_occ;
    int occ_tbl [6];
    occ_tbl = '{5, 4, 3, 3, 2, 1};

    rst_n = 1'b0;
    flush_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b0;
    flush_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;

    // Reset state
    #1;
    check("rst_vld_a", out_valid_a, 0);
    check("rst_occ_a", occ_a, 0);
    check("rst_rdy_a", in_ready_a, 0);
    check("rst_data_a", out_data_a, 0);
    check("rst_vld_b", out_valid_b, 0);
    check("rst_rdy_b", in_ready_b, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("rdy_before_edge", in_ready_a, 0);
    tick();
    check("rdy_after_edge", in_ready_a, 1);

    // Fill to occupancy 4, then reset mid-stream
    in_valid_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data_a = 8'(i + 1);
      tick();
    end
    in_valid_a = 1'b0;
    check("pre_rst_occ", occ_a, 4);
    check("pre_rst_vld", out_valid_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", out_valid_a, 0);
    check("mid_rst_occ", occ_a, 0);
    check("mid_rst_rdy", in_ready_a, 0);
    #1;
    rst_n = 1'b1;
    #1;
    check("rerst_rdy_before", in_ready_a, 0);
    tick();
    check("rerst_rdy_after", in_ready_a, 1);

    // Stream 0x01..0x10 with the output always ready
    out_ready_a = 1'b1;
    acc = 0; n_out = 0; first_acc = -1;
    for (cyc = 0; cyc < 40 && n_out < 16; cyc++) begin
      in_valid_a = (acc < 16);
      in_data_a  = 8'(acc + 1);
      #1;
      if (in_valid_a && in_ready_a) begin
        if (acc == 0) first_acc = cyc;
        acc++;
      end
      if (out_valid_a) begin
        check("stream_data", out_data_a, 32'(n_out + 1));
        check("stream_cycle", cyc, first_acc + 3 + n_out);
        n_out++;
      end
      tick();
    end
    in_valid_a = 1'b0;
    check("stream_count", n_out, 16);
    check("stream_empty", occ_a, 0);

    // Backpressure: 12 cycles with the output stalled
    out_ready_a = 1'b0;
    in_valid_a  = 1'b1;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      in_data_a = 8'(8'h21 + acc);
      #1;
      if (in_ready_a) acc++;
      tick();
    end
    check("bp_accepted", acc, 6);
    check("bp_occ", occ_a, 6);
    check("bp_rdy", in_ready_a, 0);

    // Full boundary: release output while input is also offered
    in_data_a   = 8'(8'h21 + acc);
    out_ready_a = 1'b1;
    #1;
    check("full_out_vld", out_valid_a, 1);
    check("full_in_blocked", in_ready_a, 0);
    check("full_first_data", out_data_a, 8'h21);
    tick();
    // The freed slot walks back one stage per edge because each ready is a flop
    n_out = 1;
    for (cyc = 0; cyc < 40 && n_out < 7; cyc++) begin
      in_valid_a = (acc < 7);
      in_data_a  = 8'(8'h21 + acc);
      #1;
      if (cyc < 6) check("full_occ_seq", occ_a, occ_tbl[cyc]);
      if (cyc < 3) check("full_rdy_seq", in_ready_a, (cyc == 2));
      if (in_valid_a && in_ready_a) begin
        check("full_accept_with_out", out_valid_a, 1);
        acc++;
      end
      if (out_valid_a) begin
        check("drain_data", out_data_a, 32'(8'h21 + n_out));
        n_out++;
      end
      tick();
    end
    in_valid_a = 1'b0;
    check("drain_count", n_out, 7);
    check("drain_empty", occ_a, 0);

    // Flush at occupancy 4 while 0xAA is offered
    out_ready_a = 1'b0;
    in_valid_a  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data_a = 8'(8'h31 + i);
      tick();
    end
    check("pre_flush_occ", occ_a, 4);
    in_data_a = 8'hAA;
    flush_a   = 1'b1;
    #1;
    check("flush_rdy", in_ready_a, 0);
    check("flush_vld_driven", out_valid_a, 1);
    tick();
    flush_a    = 1'b0;
    in_valid_a = 1'b0;
    check("post_flush_occ", occ_a, 0);
    check("post_flush_vld", out_valid_a, 0);
    out_ready_a = 1'b1;
    n_out = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (out_valid_a) n_out++;
      tick();
    end
    check("flush_no_output", n_out, 0);
    in_valid_a = 1'b1;
    in_data_a  = 8'h55;
    #1;
    check("post_flush_rdy", in_ready_a, 1);
    tick();
    in_valid_a = 1'b0;
    tick();
    tick();
    check("post_flush_beat_vld", out_valid_a, 1);
    check("post_flush_beat_data", out_data_a, 8'h55);
    tick();

    // SKID=0, 2 stages: toggle output ready under a continuous stream
    acc = 0; n_out = 0; max_occ = 0;
    in_valid_b = 1'b1;
    for (cyc = 0; cyc < 24; cyc++) begin
      out_ready_b = ((cyc % 2) == 1);
      in_data_b   = 8'(8'h41 + acc);
      #1;
      if (int'(occ_b) > max_occ) max_occ = int'(occ_b);
      if (occ_b == 2'd2) check("s0_rdy_follows", in_ready_b, out_ready_b);
      if (in_ready_b) acc++;
      if (out_valid_b && out_ready_b) begin
        check("s0_order", out_data_b, 32'(8'h41 + n_out));
        n_out++;
      end
      tick();
    end
    in_valid_b  = 1'b0;
    out_ready_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_valid_b) begin
        check("s0_drain_order", out_data_b, 32'(8'h41 + n_out));
        n_out++;
      end
      tick();
    end
    check("s0_capacity", max_occ, 2);
    check("s0_all_out", n_out, acc);
    check("s0_empty", occ_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
